// File: rtl/mxu_pkg.sv
// rtl/mxu_pkg.sv - shared MXU sizing, drain state encoding and flat-bus element select
//
// Purpose: common definitions imported by the MXU input feeder and the result drain.
// Contents:
//   NUM_SIZE   bit width of one result element
//   GRID_SIZE  MXU dimension (GRID_SIZE x GRID_SIZE elements per pass)
//   NUM_ELEMS  elements per pass
//   BUS_W      width of the flat result bus
//   RC_W       width of a row/column index, never below 1
//   IDX_W      width of a flat element index, never below 1
//   drain_state_e  IDLE / RUN / CAPTURE / DRAIN
//   elem_sel() element k of the flat result bus
package mxu_pkg;

  localparam int NUM_SIZE  = 16;
  localparam int GRID_SIZE = 2;
  localparam int NUM_ELEMS = GRID_SIZE * GRID_SIZE;
  localparam int BUS_W     = NUM_SIZE * NUM_ELEMS;
  localparam int RC_W      = (GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1;
  localparam int IDX_W     = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } drain_state_e;

  // Element k = i*GRID_SIZE + j sits at bits [(k+1)*NUM_SIZE-1 : k*NUM_SIZE].
  function automatic logic [NUM_SIZE-1:0] elem_sel(input logic [BUS_W-1:0] bus, input int k);
    return bus[k*NUM_SIZE +: NUM_SIZE];
  endfunction

endpackage

// File: rtl/mxu_result_drain_if.sv
// rtl/mxu_result_drain_if.sv - result element stream toward the writeback path
//
// Purpose: valid/ready stream carrying one MXU result element per handshake.
// Signals:
//   out_valid  element valid                     (master -> slave)
//   out_ready  downstream accepts the element    (slave -> master)
//   out_data   element value, NUM_SIZE bits      (master -> slave)
//   out_row    row index i, RC_W bits            (master -> slave)
//   out_col    column index j, RC_W bits         (master -> slave)
//   out_last   final element of the pass         (master -> slave)
interface mxu_result_drain_if;
  import mxu_pkg::*;

  logic                out_valid;
  logic                out_ready;
  logic [NUM_SIZE-1:0] out_data;
  logic [RC_W-1:0]     out_row;
  logic [RC_W-1:0]     out_col;
  logic                out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/mxu_result_drain.sv
// rtl/mxu_result_drain.sv - MXU output controller: settle, snapshot, row-major drain
//
// Purpose: on start, hold the MXU clock-enable high for SETTLE_CYCLES cycles,
// snapshot the flat result bus for one cycle, then stream the GRID_SIZE x GRID_SIZE
// elements out in row-major order, one per handshake.
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset; aborts any pass in flight
//   start      request one compute+drain pass, honoured only while idle
//   result_in  flat MXU result bus (BUS_W bits)
//   ce         registered MXU clock-enable
//   busy       high whenever a pass is in progress
//   done       one-cycle pulse after the final handshake
//   res        result element stream (master side)
module mxu_result_drain
  import mxu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 3 * GRID_SIZE - 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BUS_W-1:0]    result_in,
  output logic                ce,
  output logic                busy,
  output logic                done,
  mxu_result_drain_if.master  res
);

  localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(NUM_ELEMS - 1);

  drain_state_e        state_q, state_d;
  logic                ce_q, ce_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_SIZE-1:0] snap_q [NUM_ELEMS];
  logic [NUM_SIZE-1:0] snap_d [NUM_ELEMS];

  logic in_drain;
  logic is_last;
  logic handshake;

  assign in_drain  = (state_q == ST_DRAIN);
  assign is_last   = (idx_q == IDX_LAST);
  assign handshake = in_drain && res.out_ready;

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ce_d    = 1'b1;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // ce_q is already high for this cycle; drop it for the next one once the
        // last settle cycle is reached so ce spans exactly SETTLE_CYCLES cycles.
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          ce_d = 1'b1;
        end
      end

      ST_CAPTURE: begin
        for (int k = 0; k < NUM_ELEMS; k++) begin
          snap_d[k] = elem_sel(result_in, k);
        end
        idx_d   = '0;
        state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (handshake) begin
          if (is_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      for (int k = 0; k < NUM_ELEMS; k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign ce   = ce_q;
  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  // Stream fields decode only from registered state; they read 0 outside DRAIN.
  assign res.out_valid = in_drain;
  assign res.out_data  = in_drain ? snap_q[idx_q] : '0;
  assign res.out_row   = in_drain ? RC_W'(int'(idx_q) / GRID_SIZE) : '0;
  assign res.out_col   = in_drain ? RC_W'(int'(idx_q) % GRID_SIZE) : '0;
  assign res.out_last  = in_drain && is_last;

endmodule
